// File: rtl/halt_dump_unit_pkg.sv
// halt_dump_unit_pkg: shared processor defines (word width, halt word, drain length, dump FSM states)
package halt_dump_unit_pkg;
  localparam int DEF_DBITS = 32;
  localparam int DEF_NUM_REGS = 16;
  localparam logic [31:0] DEF_HALT_WORD = 32'h0000DEAD;
  localparam int DEF_DRAIN_CYCLES = 2;
  typedef enum logic [2:0] {RUN, DRAIN, FETCH, SEND, DONE} state_t;
endpackage

// File: rtl/dump_out_reg.sv
// dump_out_reg: valid/ready holding register for dumped words (load sets valid, handshake clears it)
module dump_out_reg
  import halt_dump_unit_pkg::*;
#(
  parameter int DBITS = DEF_DBITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DBITS-1:0] load_data,
  input  logic             load_last,
  input  logic             ready,
  output logic [DBITS-1:0] data,
  output logic             valid,
  output logic             last
);
  always_ff @(posedge clk)
    if (reset) begin
      data <= '0;
      valid <= 1'b0;
      last <= 1'b0;
    end else if (load) begin
      data <= load_data;
      valid <= 1'b1;
      last <= load_last;
    end else if (valid && ready) begin
      valid <= 1'b0;
      last <= 1'b0;
    end
endmodule

// File: rtl/halt_dump_unit.sv
// halt_dump_unit: halts the core on HALT_WORD, drains, then streams PC and R0..R(NUM_REGS-1) over valid/ready
module halt_dump_unit
  import halt_dump_unit_pkg::*;
#(
  parameter int               DBITS        = DEF_DBITS,
  parameter int               NUM_REGS     = DEF_NUM_REGS,
  parameter logic [DBITS-1:0] HALT_WORD    = DBITS'(DEF_HALT_WORD),
  parameter int               DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] inst_word_in,
  input  logic [DBITS-1:0] pc_in,
  output logic [3:0]       dbg_rd_addr,
  input  logic [DBITS-1:0] dbg_rd_data,
  output logic             halt_out,
  output logic [DBITS-1:0] dump_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic             dump_last,
  output logic             done
);
  localparam int CW = $clog2(DRAIN_CYCLES + 2);
  state_t state;
  logic [CW-1:0] cnt;
  logic [4:0] w;
  logic [DBITS-1:0] pc_q;
  logic halt_hit, handshake, load, load_last;
  logic [DBITS-1:0] load_data;
  assign halt_hit = state == RUN && inst_word_in == HALT_WORD;
  assign handshake = state == SEND && dump_valid && dump_ready;
  assign load = state == FETCH || (state == DRAIN && cnt == CW'(1)) || (halt_hit && DRAIN_CYCLES == 0);
  assign load_data = state == FETCH ? dbg_rd_data : state == RUN ? pc_in : pc_q;
  assign load_last = state == FETCH && w == 5'(NUM_REGS);
  assign dbg_rd_addr = state == FETCH ? 4'(w - 5'd1) : 4'd0;
  always_ff @(posedge clk)
    if (reset) begin
      state <= RUN;
      cnt <= '0;
      w <= '0;
      pc_q <= '0;
      halt_out <= 1'b0;
      done <= 1'b0;
    end else begin
      if (halt_hit) begin
        pc_q <= pc_in;
        cnt <= CW'(DRAIN_CYCLES);
        halt_out <= 1'b1;
        state <= DRAIN_CYCLES == 0 ? SEND : DRAIN;
      end
      if (state == DRAIN) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) state <= SEND;
      end
      if (state == FETCH) state <= SEND;
      if (handshake) begin
        w <= w + 5'd1;
        state <= dump_last ? DONE : FETCH;
        done <= dump_last;
      end
    end
  dump_out_reg #(.DBITS(DBITS)) u_out (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_data(load_data),
    .load_last(load_last),
    .ready(dump_ready),
    .data(dump_data),
    .valid(dump_valid),
    .last(dump_last)
  );
endmodule

// File: doc/halt_dump_unit.md
HALT_DUMP_UNIT -- requirements
Module: halt_dump_unit

Interface
REQ-001 SHALL have parameter DBITS, default 32, data/address word width.
REQ-002 SHALL have parameter NUM_REGS, default 16, number of architectural registers dumped.
REQ-003 SHALL have parameter HALT_WORD, default 32'h0000DEAD, instruction word that signals end of program.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 2, cycles waited after halt detection before dumping.
REQ-005 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have inst_word_in  input  DBITS  instruction word currently fetched by the processor.
REQ-008 SHALL have pc_in  input  DBITS  processor PC matching inst_word_in.
REQ-009 SHALL have dbg_rd_addr  output  4  register-file debug read index.
REQ-010 SHALL have dbg_rd_data  input  DBITS  register-file debug read data; valid the cycle after dbg_rd_addr is presented.
REQ-011 SHALL have halt_out  output  1  freezes processor PC/writeback when high.
REQ-012 SHALL have dump_data  output  DBITS  dumped word.
REQ-013 SHALL have dump_valid  output  1  dump_data valid.
REQ-014 SHALL have dump_ready  input  1  consumer accepts dump_data.
REQ-015 SHALL have dump_last  output  1  marks final dumped word.
REQ-016 SHALL have done  output  1  dump complete.

Function
REQ-017 SHALL implement states RUN, DRAIN, FETCH, SEND, DONE.
REQ-018 In RUN, on a rising edge with inst_word_in == HALT_WORD, SHALL latch pc_in, load drain counter with DRAIN_CYCLES, and enter DRAIN; halt_out SHALL be 1 from the following cycle.
REQ-019 DRAIN SHALL last exactly DRAIN_CYCLES cycles, then enter SEND with dump_data = latched PC and dump_valid = 1.
REQ-020 Dump order SHALL be: latched PC, then R0 .. R(NUM_REGS-1); NUM_REGS+1 words total.
REQ-021 In FETCH, dbg_rd_addr SHALL equal the register index; the next edge SHALL capture dbg_rd_data into dump_data, set dump_valid, and enter SEND (1-cycle read latency).
REQ-022 In SEND, dump_data, dump_valid and dump_last SHALL hold stable until dump_valid && dump_ready at a rising edge.
REQ-023 On handshake, SHALL clear dump_valid, then either increment the index and enter FETCH, or, if dump_last was 1, enter DONE.
REQ-024 dump_last SHALL be 1 only while sending R(NUM_REGS-1).
REQ-025 dump_valid SHALL never assert in RUN, DRAIN, FETCH or DONE; there is at most one word per two cycles.
REQ-026 In DONE, done = 1 and halt_out = 1 SHALL persist until reset.
REQ-027 HALT_WORD seen outside RUN SHALL be ignored; a PC change outside RUN SHALL not alter the latched PC.
REQ-028 dbg_rd_addr SHALL be 0 outside FETCH.
REQ-029 dump_ready high while dump_valid is low SHALL have no effect.

Reset
REQ-030 When reset = 1 at a rising edge, SHALL enter RUN with halt_out = 0, dump_valid = 0, dump_last = 0, done = 0, dump_data = 0, dbg_rd_addr = 0, index = 0, drain counter = 0, and latched PC = 0.
REQ-031 Reset SHALL take priority over every transition, including mid-DRAIN and mid-SEND; the partial dump is discarded.
REQ-032 HALT_WORD present during the reset cycle SHALL not be detected; detection resumes the first cycle after reset deasserts.

Structure
REQ-033 HALT_WORD, DRAIN_CYCLES and the state encodings SHALL live in the shared processor defines include, alongside DBITS.
REQ-034 The valid/ready output holding register SHALL be a sub-module, dump_out_reg; all other logic is in halt_dump_unit.

Verification
REQ-035 Processor halts with PC 0x0000_0040; R0..R15 = index*0x11; dump_ready tied 1 -> words 0x40, 0x00, 0x11, ... 0xFF; dump_last on 0xFF; done the next cycle.
REQ-036 dump_ready low for 5 cycles during R3 -> dump_data = 0x33 held stable with dump_valid = 1, no word lost or duplicated.
REQ-037 HALT_WORD at cycle t -> halt_out = 1 at t+1; first dump_valid at t+1+DRAIN_CYCLES (t+3 at default).
REQ-038 Reset asserted while sending R7 -> next cycle RUN, all outputs 0; a later halt restarts the dump from the PC word.
REQ-039 HALT_WORD re-presented in DONE and during SEND -> no state change; done stays 1.
REQ-040 HALT_WORD applied in the reset cycle only -> no halt; halt_out stays 0.
